// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle main control unit: state encoding,
// opcode constants and ALUOp codes handed to the ALU control decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_NANDI = 6'b001110;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_NAND  = 2'b11;

    // Terminal states retire an instruction on the edge back to FETCH.
    function automatic logic is_terminal(input logic [3:0] s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
               (s == S_BEQ)   || (s == S_IWB);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decode: maps the state register onto every datapath enable
// and mux select. Depends on state only, so outputs never see op glitches.
module mc_outdec
    import mc_pkg::*;
(
    input  logic [3:0] state,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       aluop1,
    output logic       aluop0
);

    logic [1:0] aluop;

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        aluop       = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                memread = 1'b1;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_REXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_RTYPE;
            end
            S_RWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQ: begin
                alusrca     = 1'b1;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                aluop       = ALUOP_SUB;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_NAND;
            end
            S_IWB: regwrite = 1'b1;
            default: ;
        endcase
    end

    assign aluop1 = aluop[1];
    assign aluop0 = aluop[0];

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control: opcode-driven state sequencing, retired
// instruction counter and one-cycle illegal-opcode flag.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsource,
    output logic               aluop1,
    output logic               aluop0,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count,
    output logic [3:0]         state
);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               illegal_q, illegal_d;

    always_comb begin
        state_d   = S_FETCH;
        count_d   = count_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_NANDI:     state_d = S_IEXEC;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_REXEC:  state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
        // Only terminal states retire; illegal opcodes and unreachable codes do not.
        if (is_terminal(state_q)) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    mc_outdec u_outdec (
        .state       (state_q),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .memtoreg    (memtoreg),
        .regdst      (regdst),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsource    (pcsource),
        .aluop1      (aluop1),
        .aluop0      (aluop0)
    );

    assign state       = state_q;
    assign instr_count = count_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences, illegal flag,
// counter wrap on a narrow instance, and asynchronous reset mid-instruction.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;

    logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic        memtoreg, regdst, regwrite, alusrca, aluop1, aluop0, illegal;
    logic [1:0]  alusrcb, pcsource;
    logic [15:0] instr_count;
    logic [3:0]  state;

    logic        w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite, w_irwrite;
    logic        w_memtoreg, w_regdst, w_regwrite, w_alusrca, w_aluop1, w_aluop0, w_illegal;
    logic [1:0]  w_alusrcb, w_pcsource;
    logic [3:0]  w_instr_count;
    logic [3:0]  w_state;

    int total = 0;
    int bad   = 0;
    int mw_cnt;
    logic [1:0] seen_rexec_aluop, seen_beq_aluop;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
        .aluop1(aluop1), .aluop0(aluop0), .illegal(illegal),
        .instr_count(instr_count), .state(state)
    );

    multicycle_control #(.COUNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op),
        .pcwrite(w_pcwrite), .pcwritecond(w_pcwritecond), .iord(w_iord),
        .memread(w_memread), .memwrite(w_memwrite), .irwrite(w_irwrite),
        .memtoreg(w_memtoreg), .regdst(w_regdst), .regwrite(w_regwrite),
        .alusrca(w_alusrca), .alusrcb(w_alusrcb), .pcsource(w_pcsource),
        .aluop1(w_aluop1), .aluop0(w_aluop0), .illegal(w_illegal),
        .instr_count(w_instr_count), .state(w_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (memwrite === 1'b1) mw_cnt++;
        if (state == 4'd6) seen_rexec_aluop = {aluop1, aluop0};
        if (state == 4'd8) seen_beq_aluop = {aluop1, aluop0};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Run from FETCH until FETCH comes round again; checks instruction length.
    task automatic run_instr(input string tag, input int exp_len);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (state != 4'd0 && n < 20);
        chk(tag, n, exp_len);
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'b100011;
        mw_cnt = 0;
        tick();
        chk("rst_state", state, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_fetch_ctl", {memread, irwrite, pcwrite, alusrcb, aluop1, aluop0}, 7'b111_01_00);
        tick();
        reset = 1'b0;

        // lw: 0,1,2,3,4,0
        chk("lw_s0", state, 0);
        tick(); chk("lw_s1", state, 1);
        chk("lw_dec_ctl", {memread, alusrcb}, 3'b0_11);
        tick(); chk("lw_s2", state, 2);
        chk("lw_madr_ctl", {alusrca, alusrcb, memread}, 4'b1_10_0);
        tick(); chk("lw_s3", state, 3);
        chk("lw_mrd_ctl", {memread, iord, regwrite}, 3'b110);
        tick(); chk("lw_s4", state, 4);
        chk("lw_mwb_ctl", {regwrite, memtoreg, memread}, 3'b110);
        tick(); chk("lw_s0_end", state, 0);
        chk("lw_count", instr_count, 1);
        chk("lw_fetch_ctl", {regwrite, memtoreg}, 2'b00);

        // R-type, sw, beq back-to-back after a fresh reset
        do_reset();
        mw_cnt = 0;
        seen_rexec_aluop = 2'bxx;
        seen_beq_aluop = 2'bxx;
        op = 6'b000000; run_instr("rtype_len", 4);
        op = 6'b101011; run_instr("sw_len", 4);
        op = 6'b000100; run_instr("beq_len", 3);
        chk("rexec_aluop", seen_rexec_aluop, 2'b10);
        chk("beq_aluop", seen_beq_aluop, 2'b01);
        chk("memwrite_once", mw_cnt, 1);
        chk("seq_count", instr_count, 3);

        // beq control word in detail
        tick(); chk("beq2_s1", state, 1);
        tick(); chk("beq2_s8", state, 8);
        chk("beq_ctl", {alusrca, pcwritecond, pcsource, pcwrite}, 5'b1_1_01_0);
        tick(); chk("beq2_s0", state, 0);
        chk("beq2_count", instr_count, 4);

        // nandi
        op = 6'b001110;
        tick(); chk("nandi_s1", state, 1);
        tick(); chk("nandi_s9", state, 9);
        chk("iexec_ctl", {aluop1, aluop0, alusrcb, alusrca}, 5'b11_10_1);
        tick(); chk("nandi_s10", state, 10);
        chk("iwb_ctl", {regwrite, regdst, memtoreg}, 3'b100);
        tick(); chk("nandi_s0", state, 0);
        chk("nandi_count", instr_count, 5);

        // illegal opcode
        op = 6'b111111;
        chk("ill_pre", illegal, 0);
        tick(); chk("ill_s1", state, 1);
        chk("ill_dec_flag", illegal, 0);
        tick(); chk("ill_s0", state, 0);
        chk("ill_flag", illegal, 1);
        chk("ill_count", instr_count, 5);
        op = 6'b000000;
        tick(); chk("ill_s1b", state, 1);
        chk("ill_flag_clear", illegal, 0);
        tick(); chk("ill_next_s6", state, 6);
        tick(); tick();
        chk("ill_next_count", instr_count, 6);

        // 17 R-type on the 4-bit counter wraps to 1
        do_reset();
        op = 6'b000000;
        for (int i = 0; i < 17; i++) begin
            run_instr("wrap_len", 4);
        end
        chk("wrap_count4", w_instr_count, 1);
        chk("wrap_count16", instr_count, 17);

        // asynchronous reset during MEMRD of lw
        do_reset();
        op = 6'b100011;
        tick(); tick(); tick();
        chk("ar_s3", state, 3);
        reset = 1'b1;
        #1;
        chk("ar_state_now", state, 0);
        chk("ar_count_now", instr_count, 0);
        chk("ar_no_wb", regwrite, 0);
        tick();
        chk("ar_state_held", state, 0);
        reset = 1'b0;
        tick();
        chk("ar_after_s1", state, 1);
        chk("ar_after_count", instr_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle variant of the datapath: a Moore state machine that decodes the 6-bit opcode from the instruction register and sequences every datapath enable and mux select across fetch, decode, execute, memory and write-back cycles. It sits directly upstream of the ALU control decoder, driving `aluop1`/`aluop0`; the decoder combines these with the funct bits to produce the 3-bit ALU operation. It also counts retired instructions and flags unknown opcodes.

## Interface

**Parameters**
- `COUNT_W`, default 16: width of the retired-instruction counter.

**Ports**
- `clk` input, 1: system clock, rising edge.
- `reset` input, 1: asynchronous, active-high.
- `op` input, 6: opcode, bits [31:26] of the instruction register.
- `pcwrite` output, 1: unconditional PC write.
- `pcwritecond` output, 1: PC write qualified by ALU zero.
- `iord` output, 1: memory address select (0 = PC, 1 = ALUOut).
- `memread` output, 1: memory read enable.
- `memwrite` output, 1: memory write enable.
- `irwrite` output, 1: instruction register write.
- `memtoreg` output, 1: register write-data select (1 = MDR).
- `regdst` output, 1: destination select (1 = rd, 0 = rt).
- `regwrite` output, 1: register file write.
- `alusrca` output, 1: ALU A select (0 = PC, 1 = register A).
- `alusrcb` output, 2: ALU B select (00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2).
- `pcsource` output, 2: PC source (00 = ALU result, 01 = ALUOut).
- `aluop1`, `aluop0` outputs, 1 each: to the ALU control decoder.
- `illegal` output, 1: one-cycle pulse flagging an unknown opcode.
- `instr_count` output, COUNT_W: count of retired instructions.
- `state` output, 4: current state, for debug.

## Operation

**Opcodes**
- R-type 000000, lw 100011, sw 101011, beq 000100, nandi 001110.
- All other values are illegal.

**States (encoding)**
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, BEQ 8, IEXEC 9, IWB 10.
- Codes 11–15 are unreachable and must return to FETCH on the next edge.

**Outputs per state** (Moore; any output not listed is 0)
- FETCH: memread, irwrite, pcwrite = 1; alusrcb = 01; aluop = 00.
- DECODE: alusrcb = 11; aluop = 00.
- MEMADR: alusrca = 1; alusrcb = 10; aluop = 00.
- MEMRD: memread, iord = 1.
- MEMWB: regwrite, memtoreg = 1.
- MEMWR: memwrite, iord = 1.
- REXEC: alusrca = 1; alusrcb = 00; aluop = 10.
- RWB: regdst, regwrite = 1.
- BEQ: alusrca, pcwritecond = 1; pcsource = 01; aluop = 01.
- IEXEC: alusrca = 1; alusrcb = 10; aluop = 11.
- IWB: regwrite = 1.

**Transitions**
- FETCH → DECODE.
- DECODE → MEMADR (lw/sw), REXEC (R-type), BEQ (beq), IEXEC (nandi), or FETCH (illegal).
- MEMADR → MEMRD (lw) or MEMWR (sw).
- MEMRD → MEMWB; REXEC → RWB; IEXEC → IWB.
- MEMWB, MEMWR, RWB, BEQ, IWB → FETCH.

**Opcode sampling**
- `op` is sampled only in DECODE and in MEMADR, where it is already stable because IR was written at the end of FETCH.
- `op` is ignored in all other states.

**Instruction counter**
- `instr_count` increments by 1 on each edge leaving a terminal state (MEMWB, MEMWR, RWB, BEQ, IWB).
- Illegal opcodes do not retire and do not increment the counter.
- The counter wraps modulo 2^COUNT_W.

**Illegal flag**
- `illegal` is a registered flag, set on the DECODE → FETCH illegal transition.
- It is high for exactly the following FETCH cycle.

## Timing

**Reset**
- State = FETCH, `instr_count` = 0, `illegal` = 0.
- Outputs therefore reflect the FETCH decode immediately during reset.
- Reset asserted mid-instruction abandons that instruction: no further enables for it, and no count.

**Cycles per instruction, including FETCH**
- lw 5; sw 4; R-type 4; nandi 4; beq 3; illegal 2.

**Output timing**
- All control outputs are combinational decodes of the state register only, glitch-free with respect to `op`.
- `instr_count` updates on the same edge as the terminal → FETCH transition.

## Structure

- Shared package `mc_pkg` holds:
  - the state enumeration (4-bit) with the encodings above;
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_NANDI`;
  - ALUOp constants `ALUOP_ADD` = 00, `ALUOP_SUB` = 01, `ALUOP_RTYPE` = 10, `ALUOP_NAND` = 11.
- One sub-module is natural: `mc_outdec`, the purely combinational state → control-word decoder.
- The next-state logic, counter and illegal flag stay in the top module.

## Test plan

- Reset then release with `op` = 100011: states 0, 1, 2, 3, 4, 0; `memread` = 1 in states 0 and 3; `regwrite` & `memtoreg` = 1 only in state 4; `instr_count` = 1 after 5 cycles.
- `op` = 000000, then 101011, then 000100 back-to-back: durations 4, 4, 3 cycles; aluop = 10 in REXEC and 01 in BEQ; `memwrite` is high exactly once; `instr_count` = 3.
- `op` = 001110: IEXEC drives aluop = 11, alusrcb = 10, alusrca = 1; IWB drives `regwrite` = 1 with `regdst` = 0.
- `op` = 111111: DECODE → FETCH; `illegal` high for one cycle; `instr_count` unchanged.
- COUNT_W = 4, run 17 R-type instructions: `instr_count` wraps to 1.
- Assert `reset` during MEMRD of an lw: state = 0 immediately (asynchronous); no MEMWB cycle occurs; `instr_count` = 0.
